id_ex_stage: RTL and testbench

ID/EX pipeline register with load-use hazard detection for the five-stage MIPS core. Sits directly downstream of the opcode decoder: it latches the decoder's control word plus the decode-stage operands each cycle and presents them to the execute stage. It also detects a load-use dependency, asserting `stall` to freeze PC and IF/ID while inserting a bubble. On a taken branch or jump it flushes the wrong-path instruction.

---
 rtl/id_ex_stage.sv | 135 +++++++++++++
 tb/tb_id_ex_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and flush-to-bubble.
// Optional stall-cycle counter enabled by defining ID_EX_STALL_COUNT_EN.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        flush,
  input  logic [3:0]  id_aluOp,
  input  logic        id_isJump,
  input  logic        id_isNotConditional,
  input  logic        id_isEq,
  input  logic        id_memWrite,
  input  logic        id_memRead,
  input  logic        id_aluSrc,
  input  logic        id_regDst,
  input  logic [1:0]  id_wbi,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_readData1,
  input  logic [31:0] id_readData2,
  input  logic [31:0] id_immExt,
  input  logic [31:0] id_pcNext,
  output logic [3:0]  ex_aluOp,
  output logic        ex_isJump,
  output logic        ex_isNotConditional,
  output logic        ex_isEq,
  output logic        ex_memWrite,
  output logic        ex_memRead,
  output logic        ex_aluSrc,
  output logic        ex_regDst,
  output logic [1:0]  ex_wbi,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_readData1,
  output logic [31:0] ex_readData2,
  output logic [31:0] ex_immExt,
  output logic [31:0] ex_pcNext,
  output logic        ex_valid,
  output logic        stall,
  output logic [31:0] stall_count
);

  logic [3:0]  r_aluOp;
  logic        r_isJump, r_isNotConditional, r_isEq, r_memWrite, r_memRead;
  logic        r_aluSrc, r_regDst, r_valid;
  logic [1:0]  r_wbi;
  logic [4:0]  r_rs, r_rt, r_rd;
  logic [31:0] r_readData1, r_readData2, r_immExt, r_pcNext;

  logic w_id_uses_rt;
  logic w_hazard;

  // Conditional branches compare rs against rt, so they read rt too.
  assign w_id_uses_rt = id_regDst | id_memWrite | (id_isJump & ~id_isNotConditional);
  assign w_hazard     = r_valid & r_memRead & (r_rt != 5'd0) &
                        ((r_rt == id_rs) | (w_id_uses_rt & (r_rt == id_rt)));
  assign stall        = w_hazard & ~flush;

  always_ff @(posedge clk) begin
    if (reset || flush || (enable && stall)) begin
      r_aluOp            <= '0;
      r_isJump           <= 1'b0;
      r_isNotConditional <= 1'b0;
      r_isEq             <= 1'b0;
      r_memWrite         <= 1'b0;
      r_memRead          <= 1'b0;
      r_aluSrc           <= 1'b0;
      r_regDst           <= 1'b0;
      r_wbi              <= '0;
      r_rs               <= '0;
      r_rt               <= '0;
      r_rd               <= '0;
      r_readData1        <= '0;
      r_readData2        <= '0;
      r_immExt           <= '0;
      r_pcNext           <= '0;
      r_valid            <= 1'b0;
    end else if (enable) begin
      r_aluOp            <= id_aluOp;
      r_isJump           <= id_isJump;
      r_isNotConditional <= id_isNotConditional;
      r_isEq             <= id_isEq;
      r_memWrite         <= id_memWrite;
      r_memRead          <= id_memRead;
      r_aluSrc           <= id_aluSrc;
      r_regDst           <= id_regDst;
      r_wbi              <= id_wbi;
      r_rs               <= id_rs;
      r_rt               <= id_rt;
      r_rd               <= id_rd;
      r_readData1        <= id_readData1;
      r_readData2        <= id_readData2;
      r_immExt           <= id_immExt;
      r_pcNext           <= id_pcNext;
      r_valid            <= 1'b1;
    end
  end

`ifdef ID_EX_STALL_COUNT_EN
  logic [31:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (enable && stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = '0;
`endif

  assign ex_aluOp            = r_aluOp;
  assign ex_isJump           = r_isJump;
  assign ex_isNotConditional = r_isNotConditional;
  assign ex_isEq             = r_isEq;
  assign ex_memWrite         = r_memWrite;
  assign ex_memRead          = r_memRead;
  assign ex_aluSrc           = r_aluSrc;
  assign ex_regDst           = r_regDst;
  assign ex_wbi              = r_wbi;
  assign ex_rs               = r_rs;
  assign ex_rt               = r_rt;
  assign ex_rd               = r_rd;
  assign ex_readData1        = r_readData1;
  assign ex_readData2        = r_readData2;
  assign ex_immExt           = r_immExt;
  assign ex_pcNext           = r_pcNext;
  assign ex_valid            = r_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (works with or without ID_EX_STALL_COUNT_EN).
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, enable, flush;
  logic [3:0]  id_aluOp;
  logic        id_isJump, id_isNotConditional, id_isEq, id_memWrite, id_memRead;
  logic        id_aluSrc, id_regDst;
  logic [1:0]  id_wbi;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_readData1, id_readData2, id_immExt, id_pcNext;
  logic [3:0]  ex_aluOp;
  logic        ex_isJump, ex_isNotConditional, ex_isEq, ex_memWrite, ex_memRead;
  logic        ex_aluSrc, ex_regDst, ex_valid, stall;
  logic [1:0]  ex_wbi;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_readData1, ex_readData2, ex_immExt, ex_pcNext, stall_count;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] exp_cnt = '0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .id_aluOp(id_aluOp), .id_isJump(id_isJump), .id_isNotConditional(id_isNotConditional),
    .id_isEq(id_isEq), .id_memWrite(id_memWrite), .id_memRead(id_memRead),
    .id_aluSrc(id_aluSrc), .id_regDst(id_regDst), .id_wbi(id_wbi),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_readData1(id_readData1), .id_readData2(id_readData2),
    .id_immExt(id_immExt), .id_pcNext(id_pcNext),
    .ex_aluOp(ex_aluOp), .ex_isJump(ex_isJump), .ex_isNotConditional(ex_isNotConditional),
    .ex_isEq(ex_isEq), .ex_memWrite(ex_memWrite), .ex_memRead(ex_memRead),
    .ex_aluSrc(ex_aluSrc), .ex_regDst(ex_regDst), .ex_wbi(ex_wbi),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_readData1(ex_readData1), .ex_readData2(ex_readData2),
    .ex_immExt(ex_immExt), .ex_pcNext(ex_pcNext),
    .ex_valid(ex_valid), .stall(stall), .stall_count(stall_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    id_aluOp = '0; id_isJump = 0; id_isNotConditional = 0; id_isEq = 0;
    id_memWrite = 0; id_memRead = 0; id_aluSrc = 0; id_regDst = 0; id_wbi = '0;
    id_rs = '0; id_rt = '0; id_rd = '0;
    id_readData1 = '0; id_readData2 = '0; id_immExt = '0; id_pcNext = '0;
  endtask

  // lw rt, imm(rs)
  task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt);
    set_nop();
    id_memRead = 1; id_aluSrc = 1; id_wbi = 2'b01; id_rs = rs; id_rt = rt;
    id_immExt = 32'h0000_0010; id_pcNext = 32'h0000_0100;
  endtask

  task automatic test_reset();
    reset = 1; enable = 1; flush = 0;
    id_aluOp = 4'hF; id_isJump = 1; id_isNotConditional = 1; id_isEq = 1;
    id_memWrite = 1; id_memRead = 1; id_aluSrc = 1; id_regDst = 1; id_wbi = 2'b11;
    id_rs = 5'd9; id_rt = 5'd9; id_rd = 5'd31;
    id_readData1 = 32'hDEAD_BEEF; id_readData2 = 32'hCAFE_F00D;
    id_immExt = 32'hFFFF_FFFF; id_pcNext = 32'h0040_0004;
    step(); step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ex_valid); end
    checks++; if ({ex_aluOp, ex_isJump, ex_isNotConditional, ex_isEq, ex_memWrite, ex_memRead,
                   ex_aluSrc, ex_regDst, ex_wbi} !== 13'd0) begin
      errors++; $display("FAIL reset_ctrl got nonzero control, aluOp=%h wbi=%b", ex_aluOp, ex_wbi); end
    checks++; if ({ex_rs, ex_rt, ex_rd} !== 15'd0) begin
      errors++; $display("FAIL reset_idx got rs=%0d rt=%0d rd=%0d want 0", ex_rs, ex_rt, ex_rd); end
    checks++; if ({ex_readData1, ex_readData2, ex_immExt, ex_pcNext} !== 128'd0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h want 0", ex_readData1, ex_readData2, ex_immExt, ex_pcNext); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    reset = 0;
    exp_cnt = '0;
    checks++; if (stall_count !== exp_cnt) begin errors++; $display("FAIL reset_count got %0d want %0d", stall_count, exp_cnt); end
  endtask

  task automatic test_pass_through();
    set_nop();
    id_aluOp = 4'b0010; id_regDst = 1; id_wbi = 2'b11; id_readData1 = 32'h0000_1234;
    id_readData2 = 32'h0000_5678; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd8;
    id_immExt = 32'hFFFF_FF80; id_pcNext = 32'h0000_0040; id_isEq = 1;
    step();
    checks++; if (ex_aluOp !== 4'b0010) begin errors++; $display("FAIL pass_aluOp got %b want 0010", ex_aluOp); end
    checks++; if (ex_regDst !== 1'b1 || ex_isEq !== 1'b1 || ex_memRead !== 1'b0) begin
      errors++; $display("FAIL pass_flags got regDst=%b isEq=%b memRead=%b want 1 1 0", ex_regDst, ex_isEq, ex_memRead); end
    checks++; if (ex_wbi !== 2'b11) begin errors++; $display("FAIL pass_wbi got %b want 11", ex_wbi); end
    checks++; if (ex_readData1 !== 32'h0000_1234 || ex_readData2 !== 32'h0000_5678) begin
      errors++; $display("FAIL pass_data got %h %h want 00001234 00005678", ex_readData1, ex_readData2); end
    checks++; if (ex_immExt !== 32'hFFFF_FF80 || ex_pcNext !== 32'h0000_0040) begin
      errors++; $display("FAIL pass_imm_pc got %h %h want ffffff80 00000040", ex_immExt, ex_pcNext); end
    checks++; if (ex_rs !== 5'd1 || ex_rt !== 5'd2 || ex_rd !== 5'd8) begin
      errors++; $display("FAIL pass_idx got %0d %0d %0d want 1 2 8", ex_rs, ex_rt, ex_rd); end
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL pass_valid got %b want 1", ex_valid); end
  endtask

  task automatic test_load_use();
    set_lw(5'd3, 5'd9);
    step();
    checks++; if (ex_memRead !== 1'b1 || ex_rt !== 5'd9) begin
      errors++; $display("FAIL lu_lw_loaded got memRead=%b rt=%0d want 1 9", ex_memRead, ex_rt); end
    set_nop();
    id_rs = 5'd9; id_rt = 5'd4; id_rd = 5'd5; id_regDst = 1; id_wbi = 2'b11; id_aluOp = 4'b0010;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b want 1", stall); end
    step();
`ifdef ID_EX_STALL_COUNT_EN
    exp_cnt = exp_cnt + 1;
`endif
    checks++; if (ex_valid !== 1'b0 || ex_wbi !== 2'b00 || ex_memRead !== 1'b0 || ex_rt !== 5'd0) begin
      errors++; $display("FAIL lu_bubble got valid=%b wbi=%b memRead=%b rt=%0d want 0 0 0 0", ex_valid, ex_wbi, ex_memRead, ex_rt); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_clear got %b want 0", stall); end
    step();
    checks++; if (ex_valid !== 1'b1 || ex_rs !== 5'd9 || ex_rd !== 5'd5 || ex_aluOp !== 4'b0010) begin
      errors++; $display("FAIL lu_add_loaded got valid=%b rs=%0d rd=%0d aluOp=%b want 1 9 5 0010", ex_valid, ex_rs, ex_rd, ex_aluOp); end
    checks++; if (stall_count !== exp_cnt) begin errors++; $display("FAIL lu_count got %0d want %0d", stall_count, exp_cnt); end
  endtask

  task automatic test_no_false_hazard();
    set_lw(5'd3, 5'd0);
    step();
    set_nop();
    id_rs = 5'd0; id_rt = 5'd0; id_regDst = 1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nfh_zero got %b want 0", stall); end
    set_lw(5'd3, 5'd10);
    step();
    set_nop();
    id_rs = 5'd2; id_rt = 5'd10; id_aluSrc = 1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nfh_addi got %b want 0", stall); end
    id_isJump = 1; id_isNotConditional = 1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nfh_jump got %b want 0", stall); end
    id_isNotConditional = 0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL nfh_branch_rt got %b want 1", stall); end
    id_isJump = 0; id_memWrite = 1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL nfh_sw_rt got %b want 1", stall); end
    set_nop();
    step();
  endtask

  task automatic test_flush_priority();
    set_lw(5'd3, 5'd9);
    step();
    set_nop();
    id_rs = 5'd9; id_rd = 5'd6; id_regDst = 1; id_wbi = 2'b11;
    enable = 0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fl_hold_stall got %b want 1", stall); end
    flush = 1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fl_stall got %b want 0", stall); end
    step();
    checks++; if (ex_valid !== 1'b0 || ex_memRead !== 1'b0 || ex_rt !== 5'd0 || ex_pcNext !== 32'd0) begin
      errors++; $display("FAIL fl_bubble got valid=%b memRead=%b rt=%0d pc=%h want 0 0 0 0", ex_valid, ex_memRead, ex_rt, ex_pcNext); end
    checks++; if (stall_count !== exp_cnt) begin errors++; $display("FAIL fl_count got %0d want %0d", stall_count, exp_cnt); end
    flush = 0; enable = 1;
    set_nop();
  endtask

  task automatic test_hold();
    set_lw(5'd7, 5'd9);
    id_readData1 = 32'hA5A5_0001;
    step();
    enable = 0;
    for (int i = 0; i < 3; i++) begin
      set_nop();
      id_rs = 5'd9; id_readData1 = 32'h1111_0000 + i; id_aluOp = 4'hC; id_wbi = 2'b10;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL hold_stall_%0d got %b want 1", i, stall); end
      step();
      checks++; if (ex_readData1 !== 32'hA5A5_0001 || ex_rt !== 5'd9 || ex_memRead !== 1'b1 ||
                    ex_wbi !== 2'b01 || ex_aluOp !== 4'h0 || ex_valid !== 1'b1) begin
        errors++; $display("FAIL hold_ex_%0d got rd1=%h rt=%0d memRead=%b wbi=%b valid=%b want a5a50001 9 1 01 1",
                           i, ex_readData1, ex_rt, ex_memRead, ex_wbi, ex_valid); end
      checks++; if (stall_count !== exp_cnt) begin errors++; $display("FAIL hold_count_%0d got %0d want %0d", i, stall_count, exp_cnt); end
    end
    enable = 1;
  endtask

  task automatic test_reset_mid_stall();
    // EX still holds the lw from test_hold; id_rs=9 keeps the hazard live
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rms_pre got %b want 1", stall); end
    reset = 1;
    step();
    reset = 0;
    exp_cnt = '0;
    checks++; if (ex_valid !== 1'b0 || ex_memRead !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL rms_bubble got valid=%b memRead=%b stall=%b want 0 0 0", ex_valid, ex_memRead, stall); end
    checks++; if (stall_count !== exp_cnt) begin errors++; $display("FAIL rms_count got %0d want %0d", stall_count, exp_cnt); end
  endtask

  initial begin
    reset = 1; enable = 1; flush = 0;
    set_nop();
    test_reset();
    test_pass_through();
    test_load_use();
    test_no_false_hazard();
    test_flush_priority();
    test_hold();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
